// File: rtl/frame_writeback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_writeback_ctrl
//  Description : Pixel frame buffer with a flush engine that streams the
//                stored frame (padded with FILL_WORD) to a memory-mapped
//                slave as 32-bit words.
//                Optional macro FRAME_DOUBLE_BUFFER_EN alternates the
//                destination between BASE_ADDR and ALT_BASE_ADDR per flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_writeback_ctrl #(
  parameter int                PIX_W         = 24,
  parameter int                FB_W          = 320,
  parameter int                FB_H          = 240,
  parameter int                OUT_WORDS     = 307200,
  parameter int                ADDR_W        = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 28'h8000000,
  parameter logic [ADDR_W-1:0] ALT_BASE_ADDR = 28'h8200000,
  parameter bit                CH_SWAP       = 1'b1,
  parameter logic [31:0]       FILL_WORD     = 32'h0,
  localparam int               NPIX          = FB_W * FB_H,
  localparam int               PA_W          = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_we,
  input  logic [PA_W-1:0]   pix_waddr,
  input  logic [PIX_W-1:0]  pix_wdata,
  output logic              pix_wready,
  input  logic [PA_W-1:0]   pix_raddr,
  output logic [PIX_W-1:0]  pix_rdata,
  input  logic              frame_ready,
  output logic              busy,
  output logic              done,
  output logic              av_write,
  output logic [ADDR_W-1:0] av_address,
  output logic [31:0]       av_writedata,
  input  logic              av_waitrequest,
  output logic [ADDR_W-1:0] fb_front
);

  localparam int               CW       = PIX_W / 3;
  localparam int               PAD_W    = 32 - PIX_W;
  // Wide enough to hold OUT_WORDS itself, so index arithmetic never wraps.
  localparam int               CNT_W    = $clog2(OUT_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_WORDS - 1);
  localparam logic [CNT_W-1:0] NPIX_C   = CNT_W'(NPIX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] front_q, front_d;
  logic [ADDR_W-1:0] cur_base;

  logic [PIX_W-1:0]  mem [NPIX];
  logic [PIX_W-1:0]  rd_q;
  logic [CNT_W-1:0]  rd_idx;
  logic              accept;
  logic [CW-1:0]     ch_r, ch_g, ch_b;
  logic [PIX_W-1:0]  pix_sw;

  assign cur_base   = sel_q ? ALT_BASE_ADDR : BASE_ADDR;
  assign busy       = (state_q != S_IDLE);
  assign pix_wready = !busy;
  assign av_write   = (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign accept     = av_write && !av_waitrequest;
  assign av_address = addr_q;
  assign pix_rdata  = busy ? '0 : rd_q;
  // The front buffer becomes visible during the done cycle itself.
  assign fb_front   = (state_q == S_DONE) ? cur_base : front_q;

  assign ch_r   = rd_q[PIX_W-1 -: CW];
  assign ch_g   = rd_q[2*CW-1 -: CW];
  assign ch_b   = rd_q[CW-1:0];
  assign pix_sw = CH_SWAP ? {ch_b, ch_g, ch_r} : rd_q;

  // Shared read port: host readback when idle, flush prefetch otherwise.
  // During WRITE the next word is fetched only on acceptance, so a stalled
  // word keeps re-reading the same entry and its data holds stable.
  always_comb begin
    rd_idx = CNT_W'(pix_raddr);
    unique case (state_q)
      S_PRIME: rd_idx = '0;
      S_WRITE: rd_idx = accept ? (idx_q + CNT_W'(1)) : idx_q;
      default: rd_idx = CNT_W'(pix_raddr);
    endcase
  end

  // Pixel RAM: one write port (idle only), one registered read port.
  always_ff @(posedge clk) begin
    if (pix_we && pix_wready && (CNT_W'(pix_waddr) < NPIX_C))
      mem[pix_waddr] <= pix_wdata;
    if (rd_idx < NPIX_C)
      rd_q <= mem[rd_idx[PA_W-1:0]];
  end

  // Output word formatting: pixel words for stored indices, fill beyond.
  always_comb begin
    av_writedata = '0;
    if (state_q == S_WRITE)
      av_writedata = (idx_q < NPIX_C) ? {pix_sw, {PAD_W{1'b0}}} : FILL_WORD;
  end

  // Next-state logic for the flush sequencer and its bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    front_d = front_q;
    // A single pending request absorbs any number of mid-flush requests.
    if (busy && frame_ready)
      pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (frame_ready || pend_q) begin
          state_d = S_PRIME;
          pend_d  = 1'b0;
          idx_d   = '0;
          addr_d  = cur_base;
        end
      end
      S_PRIME: state_d = S_WRITE;
      S_WRITE: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + CNT_W'(1);
            addr_d = addr_q + ADDR_W'(4);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef FRAME_DOUBLE_BUFFER_EN
        sel_d   = ~sel_q;
        front_d = cur_base;
`else
        sel_d   = 1'b0;
        front_d = BASE_ADDR;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      pend_q  <= 1'b0;
      sel_q   <= 1'b0;
      front_q <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      front_q <= front_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_writeback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_writeback_ctrl
//  Description : Self-checking bench for frame_writeback_ctrl using a small
//                frame (4x2, 12 words) and a behavioural frame/flush model.
//                Honours FRAME_DOUBLE_BUFFER_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_writeback_ctrl;

  localparam int          NW   = 12;
  localparam int          NP   = 8;
  localparam logic [27:0] BASE = 28'h8000000;
  localparam logic [27:0] ALT  = 28'h8200000;
  localparam logic [31:0] FILL = 32'h0;
`ifdef FRAME_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_we = 1'b0;
  logic [2:0]  pix_waddr = '0;
  logic [23:0] pix_wdata = '0;
  logic        pix_wready;
  logic [2:0]  pix_raddr = '0;
  logic [23:0] pix_rdata;
  logic        frame_ready = 1'b0;
  logic        busy, done, av_write;
  logic [27:0] av_address, fb_front;
  logic [31:0] av_writedata;
  logic        av_waitrequest = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] model_mem [NP];
  bit          sel_m  = 1'b0;
  bit          pend_m = 1'b0;
  logic [27:0] front_m = BASE;

  frame_writeback_ctrl #(
    .PIX_W(24), .FB_W(4), .FB_H(2), .OUT_WORDS(NW), .ADDR_W(28),
    .BASE_ADDR(BASE), .ALT_BASE_ADDR(ALT), .CH_SWAP(1'b1), .FILL_WORD(FILL)
  ) dut (
    .clk(clk), .reset(reset),
    .pix_we(pix_we), .pix_waddr(pix_waddr), .pix_wdata(pix_wdata),
    .pix_wready(pix_wready), .pix_raddr(pix_raddr), .pix_rdata(pix_rdata),
    .frame_ready(frame_ready), .busy(busy), .done(done),
    .av_write(av_write), .av_address(av_address), .av_writedata(av_writedata),
    .av_waitrequest(av_waitrequest), .fb_front(fb_front)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word n of a flush: {B,G,R,00} for stored pixels, fill word afterwards.
  function automatic logic [31:0] exp_word(input int n);
    logic [23:0] p;
    if (n >= NP) return FILL;
    p = model_mem[n];
    return {p[7:0], p[15:8], p[23:16], 8'h00};
  endfunction

  task automatic wr_pix(input logic [2:0] a, input logic [23:0] d);
    @(negedge clk);
    pix_we = 1'b1; pix_waddr = a; pix_wdata = d;
    model_mem[a] = d;
    #1 chk("wready_idle", {31'b0, pix_wready}, 32'd1);
    @(negedge clk);
    pix_we = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] a);
    @(negedge clk);
    pix_raddr = a;
    @(negedge clk);
    #1 chk("readback", {8'b0, pix_rdata}, {8'b0, model_mem[a]});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_avwrite"}, {31'b0, av_write}, 32'd0);
    chk({tag, "_addr"}, {4'b0, av_address}, {4'b0, BASE});
    chk({tag, "_wdata"}, av_writedata, 32'd0);
    chk({tag, "_front"}, {4'b0, fb_front}, {4'b0, BASE});
  endtask

  // One flush as seen from the memory side.
  // stall_mode: 0 none, 1 three-cycle stall at word 5, 2 random stalls.
  // reset_at >= 0 aborts the flush with reset when word reset_at is current.
  task automatic do_flush(input bit kick, input int stall_mode, input bit pend2,
                          input bit fr_at_done, input int reset_at);
    int          n = 0;
    int          last = 0;
    int          stalled = 0;
    int          stalls = 0;
    bit          fin = 1'b0;
    bit          exp_wr;
    logic [27:0] base;
    logic [27:0] ea;
    base = sel_m ? ALT : BASE;
    if (kick) begin
      @(negedge clk);
      frame_ready = 1'b1;
      #1 chk("idle_before_flush", {31'b0, busy}, 32'd0);
    end
    pend_m = 1'b0;
    for (int c = 1; c <= 200 && !fin; c++) begin
      @(negedge clk);
      frame_ready = 1'b0; av_waitrequest = 1'b0; pix_we = 1'b0;
      exp_wr = (c >= 2) && (n < NW);
      if (exp_wr) begin
        if (stall_mode == 1 && n == 5 && stalled < 3) begin
          av_waitrequest = 1'b1; stalled++;
        end else if (stall_mode == 2) begin
          av_waitrequest = ($urandom_range(3) == 0);
        end
      end
      if (pend2 && (c == 3 || c == 7)) frame_ready = 1'b1;
      if (fr_at_done && last != 0 && c == last + 1) frame_ready = 1'b1;
      if (frame_ready) pend_m = 1'b1;
      if (c == 4) begin
        pix_we = 1'b1; pix_waddr = 3'($urandom_range(NP - 1)); pix_wdata = 24'($urandom);
      end
      if (reset_at >= 0 && exp_wr && n == reset_at) begin
        reset = 1'b0;
        #1 check_reset_state("async_reset");
        sel_m = 1'b0; pend_m = 1'b0; front_m = BASE;
        @(negedge clk);
        chk("reset_no_done", {31'b0, done}, 32'd0);
        reset = 1'b1;
        return;
      end
      #1;
      chk("busy_in_flush", {31'b0, busy}, 32'd1);
      chk("rdata_busy", {8'b0, pix_rdata}, 32'd0);
      if (c == 4) chk("wready_busy", {31'b0, pix_wready}, 32'd0);
      chk("av_write", {31'b0, av_write}, {31'b0, exp_wr});
      chk("done", {31'b0, done}, {31'b0, (last != 0 && c == last + 1)});
      if (exp_wr) begin
        ea = base + 28'(4 * n);
        chk("av_address", {4'b0, av_address}, {4'b0, ea});
        chk("av_writedata", av_writedata, exp_word(n));
        if (av_waitrequest) stalls++;
        else begin
          n++;
          if (n == NW) last = c;
        end
      end
      if (last != 0 && c == last + 1) begin
        chk("done_cycle", c, NW + 2 + stalls);
        fin = 1'b1;
      end
    end
    if (!fin) chk("flush_timeout", 32'd0, 32'd1);
    front_m = base;
    if (DB) sel_m = ~sel_m;
    // Cycle after done is always idle.
    @(negedge clk);
    frame_ready = 1'b0; av_waitrequest = 1'b0; pix_we = 1'b0;
    #1;
    chk("idle_after_done", {31'b0, busy}, 32'd0);
    chk("fb_front", {4'b0, fb_front}, {4'b0, front_m});
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 check_reset_state("reset");
    chk("reset_wready", {31'b0, pix_wready}, 32'd1);
    reset = 1'b1;

    // Load frame: pixel 0 fixed, others random
    wr_pix(3'd0, 24'h112233);
    for (int i = 1; i < NP; i++) wr_pix(3'(i), 24'($urandom));
    for (int i = 0; i < NP; i++) rd_chk(3'(i));

    // Plain flush, no stalls: first word 33221100 at base, done 14 cycles on
    chk("first_word_model", exp_word(0), 32'h33221100);
    do_flush(1'b1, 0, 1'b0, 1'b0, -1);

    // Stall at word 5; writes attempted while busy are dropped
    do_flush(1'b1, 1, 1'b0, 1'b0, -1);
    for (int i = 0; i < NP; i++) rd_chk(3'(i));
    rd_chk(3'd0);

    // Two requests while busy -> exactly one extra flush
    do_flush(1'b1, 2, 1'b1, 1'b0, -1);
    chk("pending_set", {31'b0, pend_m}, 32'd1);
    do_flush(1'b0, 2, 1'b0, 1'b0, -1);
    @(negedge clk);
    #1 chk("no_second_pending", {31'b0, busy}, 32'd0);

    // Request coincident with done also pends
    do_flush(1'b1, 0, 1'b0, 1'b1, -1);
    do_flush(1'b0, 0, 1'b0, 1'b0, -1);
    @(negedge clk);
    #1 chk("no_extra_after_done_req", {31'b0, busy}, 32'd0);

    // Reset at word 6, then a fresh flush restarts at word 0 from BASE
    do_flush(1'b1, 0, 1'b0, 1'b0, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("post_reset_idle", {30'b0, busy, done}, 32'd0);
    end
    for (int i = 0; i < NP; i++) wr_pix(3'(i), 24'($urandom));
    do_flush(1'b1, 0, 1'b0, 1'b0, -1);

    // A few more randomized flushes with new content
    for (int k = 0; k < 3; k++) begin
      wr_pix(3'($urandom_range(NP - 1)), 24'($urandom));
      do_flush(1'b1, 2, 1'b0, 1'b0, -1);
    end
    rd_chk(3'($urandom_range(NP - 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
